// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode encoding and parameter legality check for adder_pipe
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic bit width_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - CHUNK-bit ripple of full-adder cells
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined add/subtract unit, one chunk ripple per stage, global-stall handshake
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("adder_pipe: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipe moves or holds as one; only a held result blocks it.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    assign b_eff = (sub == MODE_SUB) ? ~b : b;
    assign c0    = (sub == MODE_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * CHUNK;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]      a_src;
        logic [REM-1:0]      b_src;
        logic                c_src;
        logic                v_src;
        logic [LO+CHUNK-1:0] s_next;
        logic [CHUNK-1:0]    chunk_s;
        logic                chunk_co;
        logic                msb_carry;

        logic                v_q;
        logic                c_q;
        logic [LO+CHUNK-1:0] s_q;

        if (k == 0) begin : g_src
            assign a_src  = a;
            assign b_src  = b_eff;
            assign c_src  = c0;
            assign v_src  = in_valid;
            assign s_next = chunk_s;
        end else begin : g_src
            assign a_src  = g_stage[k-1].g_fwd.a_q;
            assign b_src  = g_stage[k-1].g_fwd.b_q;
            assign c_src  = g_stage[k-1].c_q;
            assign v_src  = g_stage[k-1].v_q;
            assign s_next = {chunk_s, g_stage[k-1].s_q};
        end

        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a        (a_src[CHUNK-1:0]),
            .b        (b_src[CHUNK-1:0]),
            .ci       (c_src),
            .s        (chunk_s),
            .co       (chunk_co),
            .c_msb_in (msb_carry)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_src;
                c_q <= chunk_co;
                s_q <= s_next;
            end
        end

        // Only operand bits not yet summed ride along; finished result bits live in s_q.
        if (k < STAGES - 1) begin : g_fwd
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;
            logic                 unused_msb_carry;

            assign unused_msb_carry = msb_carry;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_src[REM-1:CHUNK];
                    b_q <= b_src[REM-1:CHUNK];
                end
            end
        end else begin : g_out
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= msb_carry ^ chunk_co;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign s         = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_out.ovf_q;

endmodule
